seg7_scan_decoder: RTL and testbench
====================================

# seg7_scan_decoder

Receive-side counterpart of the multiplexed 4-digit seven-segment display driver. Watches the scanned anode-select and segment buses, debounces each digit slot, decodes glyphs back to BCD and checks frame format (digit-with-dot, digit, digit, blank). Reconstructs the displayed fixed-point value d.dd as an integer ×100. Used as a loopback checker and board-level display monitor.

## Interface
- SETTLE_CYCLES, 16: cycles anode and seg must be stable before a slot is sampled (≥2)
- FRAMES_MATCH, 2: consecutive identical valid frames required before a value is accepted (≥1)

- clk  in  1  system clock, 50 MHz
- rst_n  in  1  reset, synchronous, active-low
- anode  in  4  digit select, active-low one-hot; 0111=slot0 (leftmost) … 1110=slot3
- seg  in  8  segments, active-low; bit7=a … bit1=g, bit0=dp
- value_x100  out  10  accepted value, d0*100+d1*10+d2 (0..999)
- valid  out  1  one-cycle pulse when value_x100 updates
- locked  out  1  high after a value is accepted, low after any frame_err
- frame_err  out  1  one-cycle pulse on any format/glyph/order violation
- err_cnt  out  8  saturating count of frame_err pulses

## Operation
- Reset (rst_n=0 at clk edge): value_x100=0, valid=0, locked=0, frame_err=0, err_cnt=0, FSM=SYNC, settle counter=0, match count=0, all slot registers 0.
- Settle: counter clears whenever anode or seg differs from the previous cycle. When it reaches SETTLE_CYCLES-1, the slot is sampled exactly once; no further samples until anode or seg changes.
- anode=1111: counter cleared, no sample, FSM unchanged, no error.
- anode with ≠1 zero bit (e.g. 0011, 0000): frame_err, FSM→SYNC, counter cleared.
- Glyph decode of seg[7:1] (active-low): 0000001=0, 1001111=1, 0010010=2, 0000110=3, 1001100=4, 0100100=5, 0100000=6, 0001111=7, 0000000=8, 0000100=9; anything else is an unknown glyph.
- Slot rules: slot0 known glyph with dp lit (seg[0]=0); slots 1,2 known glyph with dp off; slot3 seg=11111111. Violation → frame_err, FSM→SYNC.
- FSM (advances only on a sample): SYNC: slot0 sample → GOT0, other slots ignored. GOT0: slot1 → GOT1. GOT1: slot2 → GOT2. GOT2: slot3 → frame complete, FSM→SYNC. Out-of-order legal slot in GOT0..GOT2 → frame_err; if that slot is slot0, it is stored and FSM→GOT0, else →SYNC.
- Frame complete: if candidate equals previous completed frame, match count increments (saturates at FRAMES_MATCH), else match count=1. On the transition to match count = FRAMES_MATCH: value_x100 updated, valid pulsed, locked=1. Further identical frames: no pulse.
- frame_err also clears match count and locked; value_x100 holds last accepted value. err_cnt saturates at 255.
- Arithmetic: d0*100 (7-bit product width ≥10) + d1*10 + d2 computed in 10 bits; digits guaranteed ≤9 by decode, no overflow.

## Timing
- Slot sampled on the edge where stable count reaches SETTLE_CYCLES-1 (SETTLE_CYCLES cycles after the last change).
- valid, value_x100, locked update on the edge after the slot3 sample (latency 1).
- frame_err pulses on the edge after the offending sample/anode cycle; err_cnt updated same edge.
- Error and frame-complete cannot coincide (one sample per cycle); error takes priority over any pending accept.
- Reset asserted mid-frame discards partial frame; after release, FRAMES_MATCH full frames needed before valid.

## Structure
- Package seg7_pkg: active-low glyph constants 0–9 and BLANK, anode slot constants, FSM state enum (SYNC, GOT0, GOT1, GOT2).
- Sub-module seg7_glyph_decode: combinational seg[7:1] → digit[3:0], known flag. Shared with any future display consumer.
- Settle counter width $clog2(SETTLE_CYCLES+1).

## Test plan
- Frames for "2.15" (slot0 seg=00100100, slot1 10011111, slot2 01001001, slot3 11111111), 32 cycles/slot, defaults, two frames → valid one cycle after 2nd slot3 sample, value_x100=215, locked=1.
- Third identical frame → no valid; then a frame "3.00" twice → single valid, value_x100=300.
- slot1 seg=11111110 → frame_err pulse, err_cnt=1, locked=0, value_x100 stays 300.
- Sequence 0111,1011,1110 (slot2 skipped) → frame_err, SYNC; anode=0011 → frame_err, err_cnt increments; two good frames relock.
- anode toggling every 8 cycles (< SETTLE_CYCLES) and anode=1111 gaps → no sample, no valid, no frame_err.
- rst_n=0 for one edge after slot1 of a good frame → all outputs 0 next edge; valid only after two further complete frames.

Source files
------------

// File: rtl/seg7_pkg.sv
// seg7_pkg: glyph, slot and FSM definitions shared by the seven-segment scan decoder
package seg7_pkg;
  localparam logic [6:0] GLYPH [10] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
    7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
  };
  localparam logic [7:0] BLANK = 8'hFF;
  localparam logic [3:0] SLOT0 = 4'b0111;
  localparam logic [3:0] SLOT1 = 4'b1011;
  localparam logic [3:0] SLOT2 = 4'b1101;
  localparam logic [3:0] SLOT3 = 4'b1110;
  localparam logic [3:0] IDLE  = 4'b1111;
  typedef enum logic [1:0] {SYNC = 2'd0, GOT0 = 2'd1, GOT1 = 2'd2, GOT2 = 2'd3} state_t;
endpackage

// File: rtl/seg7_glyph_decode.sv
// seg7_glyph_decode: active-low seg[7:1] pattern to BCD digit with a known-glyph flag
module seg7_glyph_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [3:0] digit_o,
  output logic       known_o
);
  // compare against every digit glyph; at most one can match
  always_comb begin
    digit_o = '0;
    known_o = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (seg_i == GLYPH[i]) begin
        digit_o = 4'(i);
        known_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: debounces a scanned 4-digit display bus and recovers the shown d.dd value
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int SETTLE_CYCLES = 16,
  parameter int FRAMES_MATCH  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] anode,
  input  logic [7:0] seg,
  output logic [9:0] value_x100,
  output logic       valid,
  output logic       locked,
  output logic       frame_err,
  output logic [7:0] err_cnt
);
  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam int MW = $clog2(FRAMES_MATCH + 1);

  logic [3:0]    anode_q;
  logic [7:0]    seg_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          smp_q, smp_d, bad_q, bad_d;
  logic          changed, idle, bad;
  state_t        state_q, state_d;
  logic [3:0]    d0_q, d0_d, d1_q, d1_d, d2_q, d2_d;
  logic [11:0]   prev_q, prev_d, cand;
  logic [MW-1:0] mcnt_q, mcnt_d;
  logic [9:0]    val_q, val_d;
  logic          valid_q, valid_d, lock_q, lock_d, err_q, err_d;
  logic [7:0]    ecnt_q, ecnt_d;
  logic [1:0]    slot;
  logic [3:0]    dig;
  logic          known, legal, in_order, complete, err, accept, same;

  seg7_glyph_decode u_dec (.seg_i(seg_q[7:1]), .digit_o(dig), .known_o(known));

  // settle counter: one sample event per stable bus value; a malformed anode is flagged once per change
  always_comb begin
    changed = (anode != anode_q) || (seg != seg_q);
    idle    = (anode == IDLE);
    bad     = !idle && !$onehot(~anode);
    cnt_d   = (changed || idle || bad) ? '0 : cnt_q + CW'(cnt_q != CW'(SETTLE_CYCLES - 1));
    smp_d   = !changed && !idle && !bad && (cnt_q == CW'(SETTLE_CYCLES - 2));
    bad_d   = bad && (anode != anode_q);
  end

  // frame tracking on the registered sample; state value equals the slot expected next
  always_comb begin
    slot     = anode_q == SLOT0 ? 2'd0 : anode_q == SLOT1 ? 2'd1 : anode_q == SLOT2 ? 2'd2 : 2'd3;
    legal    = slot == 2'd0 ? known && !seg_q[0] : slot == 2'd3 ? seg_q == BLANK : known && seg_q[0];
    in_order = 2'(state_q) == slot;
    complete = smp_q && legal && in_order && slot == 2'd3;
    err      = bad_q || (smp_q && (!legal || (state_q != SYNC && !in_order)));
    state_d  = (bad_q || (smp_q && !legal)) ? SYNC : !smp_q ? state_q : slot == 2'd0 ? GOT0 :
               (in_order && slot != 2'd3) ? state_t'(slot + 2'd1) : SYNC;
    d0_d     = (smp_q && legal && slot == 2'd0) ? dig : d0_q;
    d1_d     = (smp_q && legal && in_order && slot == 2'd1) ? dig : d1_q;
    d2_d     = (smp_q && legal && in_order && slot == 2'd2) ? dig : d2_q;
    cand     = {d0_q, d1_q, d2_q};
    same     = cand == prev_q;
    mcnt_d   = err ? '0 : !complete ? mcnt_q : !same ? MW'(1) :
               mcnt_q + MW'(mcnt_q != MW'(FRAMES_MATCH));
    accept   = complete && mcnt_d == MW'(FRAMES_MATCH) && !(same && mcnt_q == MW'(FRAMES_MATCH));
    prev_d   = complete ? cand : prev_q;
    val_d    = accept ? 10'(d0_q) * 10'd100 + 10'(d1_q) * 10'd10 + 10'(d2_q) : val_q;
    valid_d  = accept;
    lock_d   = err ? 1'b0 : accept ? 1'b1 : lock_q;
    err_d    = err;
    ecnt_d   = ecnt_q + 8'(err && ecnt_q != 8'hFF);
  end

  // state registers; the previous-input copy resets to the idle bus
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      anode_q <= IDLE;
      seg_q   <= BLANK;
      cnt_q   <= '0;
      smp_q   <= 1'b0;
      bad_q   <= 1'b0;
      state_q <= SYNC;
      d0_q    <= '0;
      d1_q    <= '0;
      d2_q    <= '0;
      prev_q  <= '0;
      mcnt_q  <= '0;
      val_q   <= '0;
      valid_q <= 1'b0;
      lock_q  <= 1'b0;
      err_q   <= 1'b0;
      ecnt_q  <= '0;
    end else begin
      anode_q <= anode;
      seg_q   <= seg;
      cnt_q   <= cnt_d;
      smp_q   <= smp_d;
      bad_q   <= bad_d;
      state_q <= state_d;
      d0_q    <= d0_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
      prev_q  <= prev_d;
      mcnt_q  <= mcnt_d;
      val_q   <= val_d;
      valid_q <= valid_d;
      lock_q  <= lock_d;
      err_q   <= err_d;
      ecnt_q  <= ecnt_d;
    end
  end

  assign value_x100 = val_q;
  assign valid      = valid_q;
  assign locked     = lock_q;
  assign frame_err  = err_q;
  assign err_cnt    = ecnt_q;
endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb_seg7_scan_decoder: vector table, corner sequences and random frames against a behavioural model
module tb_seg7_scan_decoder;
  localparam int S  = 16;
  localparam int FM = 2;
  localparam logic [6:0] GL [10] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
    7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
  };
  localparam logic [3:0] SL [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] anode = 4'hF;
  logic [7:0] seg = 8'hFF;
  logic [9:0] value_x100;
  logic valid, locked, frame_err;
  logic [7:0] err_cnt;

  seg7_scan_decoder #(.SETTLE_CYCLES(S), .FRAMES_MATCH(FM)) dut (
    .clk(clk), .rst_n(rst_n), .anode(anode), .seg(seg), .value_x100(value_x100),
    .valid(valid), .locked(locked), .frame_err(frame_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int nvalid = 0;
  int nerr = 0;

  // behavioural model: a slot is read once the bus has been seen unchanged on S consecutive edges,
  // and its effect on the outputs shows up one edge later
  int run_len = 0;
  logic [3:0] last_a = 4'hF;
  logic [7:0] last_s = 8'hFF;
  int pend = 0;
  logic [3:0] pa = 4'hF;
  logic [7:0] ps = 8'hFF;
  int digs[$];
  int last_frame = 0, streak = 0, m_val = 0, m_cnt = 0;
  bit m_valid = 0, m_lock = 0, m_err = 0;

  task automatic m_error();
    m_err = 1;
    m_cnt = m_cnt < 255 ? m_cnt + 1 : 255;
    digs.delete();
    streak = 0;
    m_lock = 0;
  endtask

  task automatic m_sample(input logic [3:0] a, input logic [7:0] s);
    int slot, d, v;
    bit ok;
    slot = a == 4'b0111 ? 0 : a == 4'b1011 ? 1 : a == 4'b1101 ? 2 : 3;
    d = -1;
    for (int i = 0; i < 10; i++) if (s[7:1] == GL[i]) d = i;
    ok = slot == 3 ? s == 8'hFF : slot == 0 ? (d >= 0 && !s[0]) : (d >= 0 && s[0]);
    if (!ok) m_error();
    else if (slot == 0) begin
      if (digs.size() != 0) m_error();
      digs = '{d};
    end else if (slot == digs.size()) begin
      if (slot < 3) digs.push_back(d);
      else begin
        v = digs[0] * 100 + digs[1] * 10 + digs[2];
        digs.delete();
        streak = v == last_frame ? streak + 1 : 1;
        last_frame = v;
        if (streak == FM) begin
          m_val = v;
          m_valid = 1;
          m_lock = 1;
        end
      end
    end else if (digs.size() != 0) m_error();
  endtask

  always @(posedge clk) begin
    m_valid = 0;
    m_err = 0;
    if (!rst_n) begin
      run_len = 0; last_a = 4'hF; last_s = 8'hFF; pend = 0; digs.delete();
      last_frame = 0; streak = 0; m_val = 0; m_cnt = 0; m_lock = 0;
    end else begin
      if (pend == 2) m_error();
      else if (pend == 1) m_sample(pa, ps);
      run_len = (anode == last_a && seg == last_s) ? run_len + 1 : 1;
      pend = 0;
      if (anode != 4'hF) begin
        if ($countones(~anode) != 1) pend = anode != last_a ? 2 : 0;
        else if (run_len == S) pend = 1;
      end
      pa = anode; ps = seg; last_a = anode; last_s = seg;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0d (0x%0h) expected %0d (0x%0h)", name, $time, act, act, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    chk("cycle_model", int'({value_x100, valid, locked, frame_err, err_cnt}),
        int'({10'(m_val), m_valid, m_lock, m_err, 8'(m_cnt)}));
    if (valid) nvalid++;
    if (frame_err) nerr++;
  endtask

  task automatic slot(input logic [3:0] a, input logic [7:0] s, input int n);
    anode = a;
    seg = s;
    repeat (n) tick();
  endtask

  task automatic frame(input logic [7:0] s0, s1, s2, s3, input int n);
    slot(SL[0], s0, n);
    slot(SL[1], s1, n);
    slot(SL[2], s2, n);
    slot(SL[3], s3, n);
  endtask

  function automatic logic [7:0] enc(input int d, input bit dp);
    return {GL[d], ~dp};
  endfunction

  typedef struct {
    logic [7:0] s0, s1, s2, s3;
    int nv, ne, val, lk, ec;
  } vec_t;
  vec_t tv [10];

  int v0, e0, d0, d1, d2, reps;
  logic [7:0] s;

  initial begin
    tv[0] = '{enc(2,1), enc(1,0), enc(5,0), 8'hFF, 0, 0,   0, 0, 0};
    tv[1] = '{enc(2,1), enc(1,0), enc(5,0), 8'hFF, 1, 0, 215, 1, 0};
    tv[2] = '{enc(2,1), enc(1,0), enc(5,0), 8'hFF, 0, 0, 215, 1, 0};
    tv[3] = '{enc(3,1), enc(0,0), enc(0,0), 8'hFF, 0, 0, 215, 1, 0};
    tv[4] = '{enc(3,1), enc(0,0), enc(0,0), 8'hFF, 1, 0, 300, 1, 0};
    tv[5] = '{enc(3,1), 8'hFE,    enc(0,0), 8'hFF, 0, 1, 300, 0, 1};
    tv[6] = '{enc(9,1), enc(8,0), enc(7,0), 8'hFF, 0, 0, 300, 0, 1};
    tv[7] = '{enc(9,1), enc(8,0), enc(7,0), 8'hFF, 1, 0, 987, 1, 1};
    tv[8] = '{enc(0,1), enc(0,0), enc(0,0), 8'hFF, 0, 0, 987, 1, 1};
    tv[9] = '{enc(0,1), enc(0,0), enc(0,0), 8'hFF, 1, 0,   0, 1, 1};
    #1;
    tick();
    tick();
    chk("reset_outputs", int'({value_x100, valid, locked, frame_err, err_cnt}), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      v0 = nvalid;
      e0 = nerr;
      frame(tv[i].s0, tv[i].s1, tv[i].s2, tv[i].s3, 32);
      chk($sformatf("vec%0d_valid", i), nvalid - v0, tv[i].nv);
      chk($sformatf("vec%0d_err", i), nerr - e0, tv[i].ne);
      chk($sformatf("vec%0d_value", i), int'(value_x100), tv[i].val);
      chk($sformatf("vec%0d_locked", i), int'(locked), tv[i].lk);
      chk($sformatf("vec%0d_errcnt", i), int'(err_cnt), tv[i].ec);
    end
    e0 = nerr;
    slot(SL[0], enc(4,1), 32);
    slot(SL[1], enc(5,0), 32);
    slot(SL[3], 8'hFF, 32);
    chk("skip_err", nerr - e0, 1);
    chk("skip_unlock", int'(locked), 0);
    slot(4'b0011, enc(1,0), 32);
    chk("anode_err_cnt", int'(err_cnt), 3);
    chk("errs_keep_value", int'(value_x100), 0);
    v0 = nvalid;
    frame(enc(2,1), enc(1,0), enc(5,0), 8'hFF, 32);
    frame(enc(2,1), enc(1,0), enc(5,0), 8'hFF, 32);
    chk("relock_valid", nvalid - v0, 1);
    chk("relock_value", int'(value_x100), 215);
    chk("relock_locked", int'(locked), 1);
    v0 = nvalid;
    e0 = nerr;
    for (int i = 0; i < 6; i++) begin
      slot(SL[0], enc(1,1), 8);
      slot(SL[1], enc(2,0), 8);
      slot(SL[2], enc(3,0), 8);
      slot(SL[3], 8'hFF, 8);
      slot(4'hF, enc(3,0), 40);
    end
    chk("fast_no_valid", nvalid - v0, 0);
    chk("fast_no_err", nerr - e0, 0);
    chk("fast_locked", int'(locked), 1);
    slot(SL[0], enc(2,1), 32);
    slot(SL[1], enc(1,0), 32);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midreset_outputs", int'({value_x100, valid, locked, frame_err, err_cnt}), 0);
    slot(SL[2], enc(5,0), 32);
    slot(SL[3], 8'hFF, 32);
    v0 = nvalid;
    frame(enc(2,1), enc(1,0), enc(5,0), 8'hFF, 32);
    chk("postreset_first", nvalid - v0, 0);
    frame(enc(2,1), enc(1,0), enc(5,0), 8'hFF, 32);
    chk("postreset_second", nvalid - v0, 1);
    chk("postreset_value", int'(value_x100), 215);
    for (int f = 0; f < 40; f++) begin
      d0 = $urandom_range(0, 9);
      d1 = $urandom_range(0, 9);
      d2 = $urandom_range(0, 9);
      reps = $urandom_range(1, 3);
      for (int r = 0; r < reps; r++) begin
        for (int k = 0; k < 4; k++) begin
          s = k == 0 ? enc(d0, 1) : k == 1 ? enc(d1, 0) : k == 2 ? enc(d2, 0) : 8'hFF;
          if ($urandom_range(0, 11) == 0) s = 8'($urandom);
          if ($urandom_range(0, 9) == 0) slot(4'($urandom), 8'($urandom), $urandom_range(1, 20));
          if ($urandom_range(0, 9) == 0) slot(4'hF, s, $urandom_range(1, 20));
          slot(SL[k], s, $urandom_range(17, 40));
        end
      end
    end
    for (int i = 0; i < 300; i++) slot(i % 2 == 1 ? 4'b0011 : 4'b0000, 8'hFF, 1);
    slot(4'hF, 8'hFF, 2);
    chk("err_cnt_saturate", int'(err_cnt), 255);
    chk("err_sat_unlocked", int'(locked), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
